pwm_capture: RTL and testbench
==============================

// Module: pwm_capture
// PURPOSE
//   Measures an incoming PWM waveform: per-period high time (duty level) and period in clk cycles.
//   Receive-side counterpart of the team's PWM generator: a generator at level L, WIDTH W reads back
//   as level_o=L, period_o=2^W. Used for loopback self-test and for reading external PWM sources.
//   Also reports stuck-high and stuck-low inputs via a timeout.
// PARAMETERS
//   WIDTH        8                  width of level_o; period_o is WIDTH+1 bits
//   INVERT       0                  1: invert pwm_in before measurement (active-low PWM)
//   SYNC_STAGES  2                  synchroniser flops on pwm_in, >=2
//   TIMEOUT      2**(WIDTH+1)-1     cycles without a rising edge before stuck is declared, >=2
// PORTS
//   clk       in   1          system clock
//   reset_n   in   1          asynchronous active-low reset
//   pwm_in    in   1          asynchronous PWM input
//   level_o   out  WIDTH      high cycles in the last complete period, saturated at 2^WIDTH-1
//   period_o  out  WIDTH+1    cycles between the last two rising edges; 0 after a timeout
//   valid_o   out  1          1-cycle pulse when level_o/period_o/stuck_o update
//   stuck_o   out  1          1 = last update was a timeout (no edges within TIMEOUT)
// BEHAVIOUR
//   Reset: one clock; reset_n asynchronous, active low. While low: level_o=0, period_o=0, valid_o=0,
//     stuck_o=0, sync chain=0, armed=0, counters=0. Applies mid-period; the partial period is discarded.
//   Input: s = last sync flop XOR INVERT; p = s registered once. rise = s & ~p.
//   Counters: per_cnt (WIDTH+1 b), high_cnt (WIDTH+1 b), both saturating at all-ones.
//   Every cycle with no rise and no timeout: per_cnt+=1, high_cnt+=s (saturating).
//   On rise:
//     armed=0 -> armed<=1 only; no valid_o.
//     armed=1 -> period_o<=per_cnt, level_o<=min(high_cnt, 2^WIDTH-1), stuck_o<=0, valid_o<=1.
//     Both cases: per_cnt<=1, high_cnt<=1 (the rise cycle is high and counts).
//   Timeout: per_cnt==TIMEOUT and no rise -> level_o<=s?{WIDTH{1}}:0, period_o<=0, stuck_o<=1,
//     valid_o<=1, armed<=0, per_cnt<=1, high_cnt<=s. While stuck persists, this repeats every
//     TIMEOUT cycles. Rise and timeout in the same cycle: rise wins.
//   Latency: rise on pwm_in -> valid_o high SYNC_STAGES+1 clk cycles later (outputs registered).
//   Outputs hold between valid_o pulses; valid_o high never lasts more than 1 cycle.
//   Period shorter than 2 cycles, or pulses narrower than 1 cycle, are not resolved.
//   Period > TIMEOUT is reported as stuck.
//   Reported high/low time can be off by +/-1 cycle per edge from synchroniser metastability.
// TESTING
//   1 WIDTH=8, generator level 64 free-running -> after 2 rises, each valid_o: level_o=64, period_o=256, stuck_o=0
//   2 Generator level 255 -> level_o=255, period_o=256; level 1 -> level_o=1, period_o=256
//   3 pwm_in held 0 (level 0) -> valid_o every 511 cycles, level_o=0, period_o=0, stuck_o=1;
//     held 1 -> level_o=255, stuck_o=1
//   4 INVERT=1, input = inverted generator at level 100 -> level_o=100, period_o=256
//   5 reset_n low mid-period, then released -> outputs 0 immediately; first rise gives no valid_o;
//     second rise gives a correct measurement
//   6 Stuck low, then PWM resumes -> first rise arms only; next period reports stuck_o=0;
//     check valid_o delay = SYNC_STAGES+1 from the rise

Source files
------------

// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and period of an asynchronous PWM input in clk cycles,
// and flags a stuck input when no rising edge arrives within TIMEOUT cycles.
module pwm_capture #(
  parameter int unsigned WIDTH       = 8,
  parameter bit          INVERT      = 1'b0,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = (2 ** (WIDTH + 1)) - 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH:0]   period_o,
  output logic             valid_o,
  output logic             stuck_o
);

  localparam int unsigned CW = WIDTH + 1;
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   in_s, in_p, rise, timeout;
  logic [CW-1:0]          per_cnt, per_nxt;
  logic [CW-1:0]          high_cnt, high_nxt;
  logic [WIDTH-1:0]       level_nxt;
  logic [WIDTH:0]         period_nxt;
  logic                   valid_nxt, stuck_nxt;

  // Synchroniser plus one-cycle delay for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      in_p   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      in_p   <= in_s;
    end
  end

  assign in_s    = sync_q[SYNC_STAGES-1] ^ INVERT;
  assign rise    = in_s & ~in_p;
  assign timeout = (per_cnt == TIMEOUT_C);

  // State, counters and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      per_cnt  <= '0;
      high_cnt <= '0;
      level_o  <= '0;
      period_o <= '0;
      valid_o  <= 1'b0;
      stuck_o  <= 1'b0;
    end else begin
      state    <= state_nxt;
      per_cnt  <= per_nxt;
      high_cnt <= high_nxt;
      level_o  <= level_nxt;
      period_o <= period_nxt;
      valid_o  <= valid_nxt;
      stuck_o  <= stuck_nxt;
    end
  end

  // Rise takes priority over timeout; first rise after idle only arms
  always_comb begin
    state_nxt  = state;
    per_nxt    = per_cnt;
    high_nxt   = high_cnt;
    level_nxt  = level_o;
    period_nxt = period_o;
    valid_nxt  = 1'b0;
    stuck_nxt  = stuck_o;
    if (rise) begin
      state_nxt = ST_ARMED;
      per_nxt   = CW'(1);
      high_nxt  = CW'(1);
      if (state == ST_ARMED) begin
        period_nxt = per_cnt;
        level_nxt  = high_cnt[WIDTH] ? {WIDTH{1'b1}} : high_cnt[WIDTH-1:0];
        stuck_nxt  = 1'b0;
        valid_nxt  = 1'b1;
      end
    end else if (timeout) begin
      state_nxt  = ST_IDLE;
      per_nxt    = CW'(1);
      high_nxt   = CW'(in_s);
      level_nxt  = in_s ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
      period_nxt = '0;
      stuck_nxt  = 1'b1;
      valid_nxt  = 1'b1;
    end else begin
      if (per_cnt != CNT_MAX) per_nxt = per_cnt + CW'(1);
      if (in_s && (high_cnt != CNT_MAX)) high_nxt = high_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: generator-style PWM at several levels, stuck inputs,
// inverted input, mid-period reset and valid latency.
module tb_pwm_capture;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned SYNC  = 2;
  localparam int          PER   = 256;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             pwm;
  logic             pwm_n;
  logic [WIDTH-1:0] level_o, iv_level_o;
  logic [WIDTH:0]   period_o, iv_period_o;
  logic             valid_o, iv_valid_o;
  logic             stuck_o, iv_stuck_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int          v_cnt = 0;
  int          v_cyc = 0;
  int          v_level = 0, v_period = 0, v_stuck = 0;
  int          iv_level = 0, iv_period = 0, iv_stuck = 0;
  logic        valid_prev = 1'b0;

  assign pwm_n = ~pwm;

  pwm_capture #(.WIDTH(WIDTH), .INVERT(1'b0), .SYNC_STAGES(SYNC)) u_dut (
    .clk(clk), .reset_n(reset_n), .pwm_in(pwm),
    .level_o(level_o), .period_o(period_o), .valid_o(valid_o), .stuck_o(stuck_o)
  );

  pwm_capture #(.WIDTH(WIDTH), .INVERT(1'b1), .SYNC_STAGES(SYNC)) u_inv (
    .clk(clk), .reset_n(reset_n), .pwm_in(pwm_n),
    .level_o(iv_level_o), .period_o(iv_period_o), .valid_o(iv_valid_o), .stuck_o(iv_stuck_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Record every valid pulse of both instances; valid must never last two cycles
  always @(negedge clk) begin
    if (valid_o) begin
      check("valid_width", 32'(valid_prev), 32'd0);
      v_cnt++;
      v_cyc    = cyc;
      v_level  = int'(level_o);
      v_period = int'(period_o);
      v_stuck  = int'(stuck_o);
    end
    valid_prev = valid_o;
    if (iv_valid_o) begin
      iv_level  = int'(iv_level_o);
      iv_period = int'(iv_period_o);
      iv_stuck  = int'(iv_stuck_o);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_period(input int lvl);
    pwm = 1'b1;
    repeat (lvl) step();
    pwm = 1'b0;
    repeat (PER - lvl) step();
  endtask

  task automatic wait_valid(input string tag, input int max_cyc);
    int  start;
    bit  seen;
    start = v_cnt;
    seen  = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      step();
      if (v_cnt != start) seen = 1'b1;
    end
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_level(input string tag, input int lvl, input int nper, input int exp_cnt);
    int c0;
    c0 = v_cnt;
    repeat (nper) drive_period(lvl);
    check({tag, "_cnt"},    32'(v_cnt - c0), 32'(exp_cnt));
    check({tag, "_level"},  32'(v_level),    32'(lvl));
    check({tag, "_period"}, 32'(v_period),   32'(PER));
    check({tag, "_stuck"},  32'(v_stuck),    32'd0);
  endtask

  initial begin
    int t0, c0, lat;
    reset_n = 1'b0;
    pwm     = 1'b0;
    repeat (2) step();
    check("rst_level",  32'(level_o),  32'd0);
    check("rst_period", 32'(period_o), 32'd0);
    check("rst_valid",  32'(valid_o),  32'd0);
    check("rst_stuck",  32'(stuck_o),  32'd0);
    reset_n = 1'b1;
    step();

    // Free-running generator at several levels; first rise after reset only arms
    run_level("l64", 64, 4, 3);
    run_level("l255", 255, 3, 3);
    run_level("l1", 1, 3, 3);
    run_level("l100", 100, 3, 3);
    check("inv_level",  32'(iv_level),  32'd100);
    check("inv_period", 32'(iv_period), 32'(PER));
    check("inv_stuck",  32'(iv_stuck),  32'd0);

    // Stuck low: repeated timeouts every 511 cycles
    wait_valid("stk0", 600);
    check("stk0_level",  32'(v_level),  32'd0);
    check("stk0_period", 32'(v_period), 32'd0);
    check("stk0_stuck",  32'(v_stuck),  32'd1);
    t0 = v_cyc;
    wait_valid("stk0b", 600);
    check("stk0_interval", 32'(v_cyc - t0), 32'd511);

    // Stuck high: the rise only arms, then a high timeout
    pwm = 1'b1;
    wait_valid("stk1", 600);
    check("stk1_level",  32'(v_level),  32'd255);
    check("stk1_period", 32'(v_period), 32'd0);
    check("stk1_stuck",  32'(v_stuck),  32'd1);
    t0 = v_cyc;
    wait_valid("stk1b", 600);
    check("stk1_interval", 32'(v_cyc - t0), 32'd511);

    // Back to stuck low, then resume PWM
    pwm = 1'b0;
    wait_valid("stk0c", 600);
    check("stk0c_level", 32'(v_level), 32'd0);
    check("stk0c_stuck", 32'(v_stuck), 32'd1);
    c0 = v_cnt;
    drive_period(64);
    check("arm_only", 32'(v_cnt - c0), 32'd0);
    pwm = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (valid_o && lat == 0) lat = k;
    end
    repeat (44) step();
    pwm = 1'b0;
    repeat (PER - 64) step();
    check("latency",       32'(lat),      32'(SYNC + 1));
    check("resume_level",  32'(v_level),  32'd64);
    check("resume_period", 32'(v_period), 32'(PER));
    check("resume_stuck",  32'(v_stuck),  32'd0);

    // Reset in the middle of a period
    pwm = 1'b1;
    repeat (64) step();
    pwm = 1'b0;
    repeat (36) step();
    reset_n = 1'b0;
    #1;
    check("mrst_level",  32'(level_o),  32'd0);
    check("mrst_period", 32'(period_o), 32'd0);
    check("mrst_valid",  32'(valid_o),  32'd0);
    check("mrst_stuck",  32'(stuck_o),  32'd0);
    repeat (2) step();
    reset_n = 1'b1;
    c0 = v_cnt;
    drive_period(64);
    check("mrst_arm_only", 32'(v_cnt - c0), 32'd0);
    drive_period(64);
    check("mrst_cnt",    32'(v_cnt - c0), 32'd1);
    check("mrst_level2", 32'(v_level),    32'd64);
    check("mrst_period2", 32'(v_period),  32'(PER));
    check("mrst_stuck2", 32'(v_stuck),    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
